// File: rtl/rob_reload_seq_pkg.sv
// -----------------------------------------------------------------------------
// rob_reload_seq_pkg
// Shared definitions for the ROB-side reload sequencer:
//   - FSM state encoding
//   - reload-cause constants (branch mispredict / exception)
//   - 1-bit strobe values used when driving pulse outputs
//   - helper that selects the reload cause of a committing entry
// -----------------------------------------------------------------------------
package rob_reload_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RELOAD   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_COPY     = 3'd3,
    ST_DONE     = 3'd4
  } rld_state_e;

  // Reload cause of the committing head entry.
  localparam logic RLD_BR  = 1'b0;
  localparam logic RLD_EXC = 1'b1;

  // Strobe levels: EnableValue raises a pulse, AbleValue drops it.
  localparam logic EnableValue = 1'b1;
  localparam logic AbleValue   = 1'b0;

  // An exception wins over a mispredict when both flags are set.
  function automatic logic rld_cause(input logic excp);
    return excp ? RLD_EXC : RLD_BR;
  endfunction

endpackage

// File: rtl/rob_remap_stepper.sv
// -----------------------------------------------------------------------------
// rob_remap_stepper
// Beat counter / address stepper for the aRAT->RAT copy.
// Ports:
//   Clk, Rest  : clock, asynchronous active-high reset
//   i_load     : restart the beat counter at beat 0 (entry into the copy)
//   i_step     : advance one beat; the last beat wraps back to 0
//   o_base     : first architectural register of the current beat
//   o_last     : current beat is the final one
// The counter wraps to 0 after the last beat so o_base reads 0 whenever
// no copy is in progress.
// -----------------------------------------------------------------------------
module rob_remap_stepper
  import rob_reload_seq_pkg::*;
#(
  parameter int AREG_NUM   = 32,
  parameter int COPY_LANES = 4,
  parameter int BASE_W     = 5
)(
  input  logic              Clk,
  input  logic              Rest,
  input  logic              i_load,
  input  logic              i_step,
  output logic [BASE_W-1:0] o_base,
  output logic              o_last
);

  localparam int BEATS  = AREG_NUM / COPY_LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [BEAT_W-1:0] r_beat;

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_beat <= '0;
    end else if (i_load) begin
      r_beat <= '0;
    end else if (i_step) begin
      r_beat <= o_last ? '0 : (r_beat + BEAT_W'(1));
    end
  end

  assign o_last = (r_beat == LAST_BEAT);
  assign o_base = BASE_W'(r_beat) * BASE_W'(COPY_LANES);

endmodule

// File: rtl/rob_reload_seq.sv
// -----------------------------------------------------------------------------
// rob_reload_seq
// ROB-side generator of the pipeline reload protocol. Watches the ROB head at
// commit; on a mispredicted branch or an exception it pulses ROBReload with
// the redirect PC, waits for the aRATRemapping acknowledge (bounded by
// ACK_TIMEOUT), steps the aRAT->RAT copy in COPY_LANES-wide beats and then
// pulses RemapDone. Commit is stalled for the whole sequence.
//
// Handshake: ROBReload/RedirectValid are one-cycle pulses issued in RELOAD.
// aRATRemapping is only sampled in WAIT_ACK; a high level in any other state
// has no effect. If it does not arrive within ACK_TIMEOUT WAIT_ACK cycles the
// copy starts anyway and the sticky AckTimeout flag is set.
//
// Ports:
//   Clk, Rest                inputs : clock, asynchronous active-high reset
//   CmtValid/Mispred/Excp    inputs : head-entry commit and its event flags
//   CmtExcode/CmtPc          inputs : head-entry exception code and PC
//   CmtTargetPc              input  : resolved branch target
//   ExcpEntryPc              input  : CSR exception entry address
//   aRATRemapping            input  : acknowledge from the flush controller
//   ROBReload/RedirectValid  outputs: reload pulse, redirect pulse
//   RedirectPc               output : fetch restart PC (held until next event)
//   ExcpValid/ExcpCode/ExcpPc outputs: exception pulse and captured info
//   CommitStall              output : high while a reload is in progress
//   RemapValid/RemapBase     outputs: copy beat strobe and first reg of beat
//   RemapDone                output : pulse after the last beat
//   AckTimeout               output : sticky missed-ack flag
//   o_dbg_state              output : current FSM state
// All outputs are registered.
// -----------------------------------------------------------------------------
module rob_reload_seq
  import rob_reload_seq_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int AREG_NUM    = 32,
  parameter int COPY_LANES  = 4,
  parameter int EXCODE_W    = 6,
  parameter int ACK_TIMEOUT = 7,
  localparam int BASE_W     = $clog2(AREG_NUM)
)(
  input  logic                Clk,
  input  logic                Rest,
  input  logic                CmtValid,
  input  logic                CmtMispred,
  input  logic                CmtExcp,
  input  logic [EXCODE_W-1:0] CmtExcode,
  input  logic [PC_W-1:0]     CmtPc,
  input  logic [PC_W-1:0]     CmtTargetPc,
  input  logic [PC_W-1:0]     ExcpEntryPc,
  input  logic                aRATRemapping,
  output logic                ROBReload,
  output logic                RedirectValid,
  output logic [PC_W-1:0]     RedirectPc,
  output logic                ExcpValid,
  output logic [EXCODE_W-1:0] ExcpCode,
  output logic [PC_W-1:0]     ExcpPc,
  output logic                CommitStall,
  output logic                RemapValid,
  output logic [BASE_W-1:0]   RemapBase,
  output logic                RemapDone,
  output logic                AckTimeout,
  output logic [2:0]          o_dbg_state
);

  generate
    if ((AREG_NUM % COPY_LANES) != 0) begin : g_bad_lanes
      $error("rob_reload_seq: AREG_NUM must be a multiple of COPY_LANES");
    end
    if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > 8)) begin : g_bad_timeout
      $error("rob_reload_seq: ACK_TIMEOUT must fit the 3-bit wait counter (1..8)");
    end
  endgenerate

  // The wait counter starts at 0 on entry, so the last allowed WAIT_ACK
  // cycle is the one where it reads ACK_TIMEOUT-1.
  localparam logic [2:0] ACK_LIMIT = 3'(ACK_TIMEOUT - 1);

  rld_state_e          r_state;
  logic [2:0]          r_ack_cnt;
  logic                r_rob_reload;
  logic                r_redirect_valid;
  logic [PC_W-1:0]     r_redirect_pc;
  logic                r_excp_valid;
  logic [EXCODE_W-1:0] r_excp_code;
  logic [PC_W-1:0]     r_excp_pc;
  logic                r_stall;
  logic                r_remap_valid;
  logic                r_remap_done;
  logic                r_ack_timeout;

  logic                w_event;
  logic                w_cause;
  logic                w_ack_expired;
  logic                w_copy_start;
  logic                w_copy_step;
  logic                w_last_beat;
  logic [BASE_W-1:0]   w_remap_base;

  assign w_event       = CmtValid & (CmtMispred | CmtExcp);
  assign w_cause       = rld_cause(CmtExcp);
  assign w_ack_expired = (r_ack_cnt == ACK_LIMIT);
  assign w_copy_start  = (r_state == ST_WAIT_ACK) & (aRATRemapping | w_ack_expired);
  assign w_copy_step   = (r_state == ST_COPY);

  rob_remap_stepper #(
    .AREG_NUM   (AREG_NUM),
    .COPY_LANES (COPY_LANES),
    .BASE_W     (BASE_W)
  ) u_stepper (
    .Clk    (Clk),
    .Rest   (Rest),
    .i_load (w_copy_start),
    .i_step (w_copy_step),
    .o_base (w_remap_base),
    .o_last (w_last_beat)
  );

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_state          <= ST_IDLE;
      r_ack_cnt        <= '0;
      r_rob_reload     <= AbleValue;
      r_redirect_valid <= AbleValue;
      r_redirect_pc    <= '0;
      r_excp_valid     <= AbleValue;
      r_excp_code      <= '0;
      r_excp_pc        <= '0;
      r_stall          <= AbleValue;
      r_remap_valid    <= AbleValue;
      r_remap_done     <= AbleValue;
      r_ack_timeout    <= AbleValue;
    end else begin
      // Pulses default low; only the state that owns them raises them.
      r_rob_reload     <= AbleValue;
      r_redirect_valid <= AbleValue;
      r_excp_valid     <= AbleValue;
      r_remap_done     <= AbleValue;

      case (r_state)
        ST_IDLE: begin
          if (w_event) begin
            r_redirect_pc    <= (w_cause == RLD_EXC) ? ExcpEntryPc : CmtTargetPc;
            r_excp_pc        <= CmtPc;
            r_excp_code      <= CmtExcode;
            r_rob_reload     <= EnableValue;
            r_redirect_valid <= EnableValue;
            r_excp_valid     <= (w_cause == RLD_EXC);
            r_stall          <= EnableValue;
            r_state          <= ST_RELOAD;
          end
        end

        ST_RELOAD: begin
          r_ack_cnt <= '0;
          r_state   <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (aRATRemapping) begin
            r_remap_valid <= EnableValue;
            r_state       <= ST_COPY;
          end else if (w_ack_expired) begin
            r_ack_timeout <= EnableValue;
            r_remap_valid <= EnableValue;
            r_state       <= ST_COPY;
          end else begin
            r_ack_cnt <= r_ack_cnt + 3'd1;
          end
        end

        ST_COPY: begin
          if (w_last_beat) begin
            r_remap_valid <= AbleValue;
            r_remap_done  <= EnableValue;
            r_state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_stall <= AbleValue;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Upstream must hold commit while CommitStall is high; any commit seen
  // then is ignored by the FSM and recorded here.
  c_cmt_while_stalled: cover property (
    @(posedge Clk) disable iff (Rest) (CmtValid && CommitStall)
  );

  assign ROBReload     = r_rob_reload;
  assign RedirectValid = r_redirect_valid;
  assign RedirectPc    = r_redirect_pc;
  assign ExcpValid     = r_excp_valid;
  assign ExcpCode      = r_excp_code;
  assign ExcpPc        = r_excp_pc;
  assign CommitStall   = r_stall;
  assign RemapValid    = r_remap_valid;
  assign RemapBase     = w_remap_base;
  assign RemapDone     = r_remap_done;
  assign AckTimeout    = r_ack_timeout;
  assign o_dbg_state   = r_state;

endmodule
